// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: takes one PC per handshake, reads instruction memory over a single-beat
// AR/R read, and holds {inst, inst_pc, inst_fault} for decode until it is accepted.
module ysyx_23060096_ifu #(
    parameter int          TIMEOUT    = 256,
    parameter logic [31:0] FAULT_INST = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state, state_next;
    logic          drop, drop_next;
    logic [CW-1:0] tmo_cnt, tmo_cnt_next;
    logic [31:0]   pc_q, pc_q_next;
    logic [31:0]   inst_q, inst_next;
    logic          fault_q, fault_next;

    logic pc_hs, ar_hs, r_hs, kill;

    // Every valid/ready output is forced low while reset is held, whatever the state.
    assign pc_ready   = rstn && (state == IDLE) && !flush;
    assign ar_valid   = rstn && (state == ADDR);
    assign r_ready    = rstn && (state == DATA);
    assign inst_valid = rstn && (state == HOLD);

    assign ar_addr    = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = pc_q;
    assign inst_fault = fault_q;

    assign pc_hs = pc_valid && pc_ready;
    assign ar_hs = ar_valid && ar_ready;
    assign r_hs  = r_valid && r_ready;
    // A fetch is abandoned if flushed earlier or in this very cycle.
    assign kill  = drop || flush;

    always_comb begin
        state_next   = state;
        drop_next    = drop;
        tmo_cnt_next = tmo_cnt;
        pc_q_next    = pc_q;
        inst_next    = inst_q;
        fault_next   = fault_q;
        case (state)
            IDLE: begin
                if (pc_hs) begin
                    pc_q_next = pc_in;
                    if (pc_in[1:0] != 2'b00) begin
                        state_next = HOLD;
                        inst_next  = FAULT_INST;
                        fault_next = 1'b1;
                    end else begin
                        state_next = ADDR;
                    end
                end
            end
            ADDR: begin
                // The address cannot be withdrawn, so a flush only marks the reply for discard.
                if (flush) drop_next = 1'b1;
                if (ar_hs) begin
                    state_next   = DATA;
                    tmo_cnt_next = '0;
                end
            end
            DATA: begin
                drop_next = kill;
                if (r_hs) begin
                    if (kill) begin
                        state_next = IDLE;
                        drop_next  = 1'b0;
                    end else begin
                        state_next = HOLD;
                        inst_next  = r_data;
                        fault_next = (r_resp != 2'b00);
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    drop_next = 1'b0;
                    if (kill) begin
                        state_next = IDLE;
                    end else begin
                        state_next = HOLD;
                        inst_next  = FAULT_INST;
                        fault_next = 1'b1;
                    end
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (flush || inst_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            drop    <= 1'b0;
            tmo_cnt <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            drop    <= drop_next;
            tmo_cnt <= tmo_cnt_next;
            pc_q    <= pc_q_next;
            inst_q  <= inst_next;
            fault_q <= fault_next;
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Directed bench for the fetch unit: drives PC, memory and decode sides by hand and
// checks each observed output against hand-computed values.
module tb_ysyx_23060096_ifu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] pc_in;
    logic        flush;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    int checks = 0;
    int errors = 0;
    int ar_cnt = 0;
    int r_cnt  = 0;

    ysyx_23060096_ifu #(.TIMEOUT(8), .FAULT_INST(32'h0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .pc_in      (pc_in),
        .flush      (flush),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ar_valid && ar_ready) ar_cnt <= ar_cnt + 1;
        if (r_valid && r_ready)   r_cnt  <= r_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch with programmable wait states on AR, R and decode.
    task automatic fetch(input logic [31:0] pc, input int ar_dly, input int r_dly, input int i_dly,
                         input logic [31:0] data, input logic [1:0] resp, input logic exp_fault);
        int ar0, r0;
        ar0 = ar_cnt;
        r0  = r_cnt;
        check("idle_pc_ready", pc_ready, 1);
        pc_valid = 1; pc_in = pc;
        tick();
        pc_valid = 0;
        check("ar_valid", ar_valid, 1);
        check("ar_addr", ar_addr, pc);
        check("pc_ready_busy", pc_ready, 0);
        for (int i = 0; i < ar_dly; i++) begin
            tick();
            check("ar_valid_wait", ar_valid, 1);
            check("ar_addr_stable", ar_addr, pc);
        end
        ar_ready = 1;
        tick();
        ar_ready = 0;
        check("data_ar_valid", ar_valid, 0);
        check("r_ready", r_ready, 1);
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check("r_wait_inst_valid", inst_valid, 0);
        end
        r_valid = 1; r_data = data; r_resp = resp;
        tick();
        r_valid = 0; r_data = 32'h1111_1111; r_resp = 2'b00;
        check("inst_valid", inst_valid, 1);
        check("inst", inst, data);
        check("inst_pc", inst_pc, pc);
        check("inst_fault", inst_fault, exp_fault);
        check("hold_r_ready", r_ready, 0);
        for (int i = 0; i < i_dly; i++) begin
            tick();
            check("hold_valid", inst_valid, 1);
            check("hold_inst", inst, data);
            check("hold_inst_pc", inst_pc, pc);
            check("hold_pc_ready", pc_ready, 0);
        end
        inst_ready = 1;
        tick();
        inst_ready = 0;
        check("after_hs_valid", inst_valid, 0);
        check("after_hs_pc_ready", pc_ready, 1);
        check("ar_count", ar_cnt - ar0, 1);
        check("r_count", r_cnt - r0, 1);
    endtask

    initial begin
        int ar0, r0;
        rstn = 0; pc_valid = 0; pc_in = 0; flush = 0; ar_ready = 0;
        r_valid = 0; r_data = 0; r_resp = 0; inst_ready = 0;
        #1;
        check("rst_pc_ready", pc_ready, 0);
        tick(); tick();
        check("rst_pc_ready2", pc_ready, 0);
        check("rst_ar_valid", ar_valid, 0);
        check("rst_inst_fault", inst_fault, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        rstn = 1;
        tick();

        // 1: zero-wait fetch
        fetch(32'h8000_0000, 0, 0, 0, 32'h0000_0413, 2'b00, 1'b0);
        // 2: stalls on every channel
        fetch(32'h8000_0004, 3, 2, 4, 32'h0010_0093, 2'b00, 1'b0);
        // 3b: bus error response
        fetch(32'h8000_000c, 0, 0, 0, 32'h1234_5678, 2'b10, 1'b1);

        // 3: misaligned PC faults without touching the bus
        ar0 = ar_cnt;
        pc_valid = 1; pc_in = 32'h8000_0002;
        tick();
        pc_valid = 0;
        check("mis_ar_valid", ar_valid, 0);
        check("mis_inst_valid", inst_valid, 1);
        check("mis_inst", inst, 0);
        check("mis_fault", inst_fault, 1);
        check("mis_inst_pc", inst_pc, 32'h8000_0002);
        inst_ready = 1;
        tick();
        inst_ready = 0;
        check("mis_done", inst_valid, 0);
        check("mis_no_ar", ar_cnt - ar0, 0);

        // flush in IDLE blocks PC acceptance
        flush = 1; pc_valid = 1; pc_in = 32'h8000_0040;
        #1;
        check("flush_idle_pc_ready", pc_ready, 0);
        tick();
        flush = 0; pc_valid = 0;
        check("flush_idle_no_ar", ar_valid, 0);

        // 4: flush while the address is pending
        r0 = r_cnt;
        pc_valid = 1; pc_in = 32'h8000_0008;
        tick();
        pc_valid = 0; flush = 1;
        tick();
        flush = 0;
        check("flush_addr_ar_held", ar_valid, 1);
        ar_ready = 1;
        tick();
        ar_ready = 0;
        check("flush_r_ready", r_ready, 1);
        r_valid = 1; r_data = 32'hDEAD_BEEF;
        tick();
        r_valid = 0;
        check("flush_no_inst", inst_valid, 0);
        check("flush_r_consumed", r_cnt - r0, 1);
        check("flush_back_idle", pc_ready, 1);
        fetch(32'h8000_0010, 0, 0, 0, 32'h0000_0513, 2'b00, 1'b0);

        // flush in HOLD drops the presented instruction even with decode ready
        pc_valid = 1; pc_in = 32'h8000_0001;
        tick();
        pc_valid = 0;
        check("hold_flush_pre", inst_valid, 1);
        flush = 1; inst_ready = 1;
        tick();
        flush = 0; inst_ready = 0;
        check("hold_flush_valid", inst_valid, 0);

        // 5: timeout after 8 DATA cycles
        pc_valid = 1; pc_in = 32'h8000_0020;
        tick();
        pc_valid = 0; ar_ready = 1;
        tick();
        ar_ready = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("tmo_wait", inst_valid, 0);
        end
        tick();
        check("tmo_valid", inst_valid, 1);
        check("tmo_fault", inst_fault, 1);
        check("tmo_inst", inst, 0);
        check("tmo_inst_pc", inst_pc, 32'h8000_0020);
        inst_ready = 1;
        tick();
        inst_ready = 0;

        // reset mid-DATA abandons the fetch
        pc_valid = 1; pc_in = 32'h8000_0030;
        tick();
        pc_valid = 0; ar_ready = 1;
        tick();
        ar_ready = 0;
        check("pre_rst_r_ready", r_ready, 1);
        rstn = 0;
        tick();
        check("rst_r_ready", r_ready, 0);
        check("rst_ar_valid2", ar_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_pc_ready3", pc_ready, 0);
        rstn = 1;
        #1;
        check("rel_pc_ready", pc_ready, 1);
        tick();
        check("rel_idle_ar", ar_valid, 0);
        fetch(32'h8000_0100, 1, 1, 1, 32'h0000_0073, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
